triangle_monitor: RTL and testbench

- Receive-side checker for the 4-bit up/down triangle counter stream.
- Samples the count value, locks onto the sequence 0,0,1..MAX,MAX,MAX-1..1 and repeats.
- Reports direction, peak and trough events, the measured period and protocol errors.
- Sits at the consuming end of the counter output, in the same FPGA test designs.

---
 rtl/triangle_monitor.sv | 126 ++++++++++++
 tb/tb_triangle_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_monitor.sv
// Receive-side checker for an up/down triangle count stream: locks onto
// 0,0,1..MAX,MAX,MAX-1..1, flags violations and measures the peak-to-peak period.
module triangle_monitor #(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VALID,
   input  logic [W-1:0]  IN,
   output logic          LOCKED,
   output logic          DIR,
   output logic          PEAK,
   output logic          TROUGH,
   output logic          ERR,
   output logic [CW-1:0] ERR_CNT,
   output logic [CW-1:0] PERIOD
);

   localparam logic [W-1:0] MAX = '1;
   localparam logic [W-1:0] ONE = W'(1);

   typedef enum logic [2:0] {ACQ0, ACQ1, UP, TOP1, DOWN, BOT1} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  p;
   logic [CW-1:0] cnt;
   logic          peak_seen;
   logic          is_inc, is_dec, locked_cur;
   logic          peak_d, trough_d, err_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   // Neighbour tests never wrap: MAX has no successor, 0 has no predecessor.
   always_comb begin
      is_inc     = (p != MAX) && (IN == p + ONE);
      is_dec     = (p != '0)  && (IN == p - ONE);
      locked_cur = state inside {UP, TOP1, DOWN, BOT1};
   end

   always_comb begin
      state_nxt = state;
      peak_d    = 1'b0;
      trough_d  = 1'b0;
      err_d     = 1'b0;
      if (IN_VALID) begin
         case (state)
            ACQ0: state_nxt = ACQ1;
            ACQ1: begin
               if (is_inc)                         state_nxt = (IN == MAX) ? TOP1 : UP;
               else if (is_dec)                    state_nxt = (IN == '0) ? BOT1 : DOWN;
               else if ((IN == MAX) && (p == MAX)) state_nxt = DOWN;
               else if ((IN == '0) && (p == '0))   state_nxt = UP;
            end
            UP: begin
               if (is_inc) state_nxt = (IN == MAX) ? TOP1 : UP;
               else        err_d = 1'b1;
            end
            TOP1: begin
               if (IN == MAX) begin
                  state_nxt = DOWN;
                  peak_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            DOWN: begin
               if (is_dec) state_nxt = (IN == '0) ? BOT1 : DOWN;
               else        err_d = 1'b1;
            end
            BOT1: begin
               if (IN == '0) begin
                  state_nxt = UP;
                  trough_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_nxt = ACQ0;
         endcase
         // The offending sample becomes the first sample of reacquisition.
         if (err_d) state_nxt = ACQ1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ACQ0;
         p         <= '0;
         LOCKED    <= 1'b0;
         DIR       <= 1'b0;
         PEAK      <= 1'b0;
         TROUGH    <= 1'b0;
         ERR       <= 1'b0;
         ERR_CNT   <= '0;
         PERIOD    <= '0;
         cnt       <= '0;
         peak_seen <= 1'b0;
      end else begin
         state  <= state_nxt;
         LOCKED <= state_nxt inside {UP, TOP1, DOWN, BOT1};
         DIR    <= state_nxt inside {DOWN, BOT1};
         PEAK   <= peak_d;
         TROUGH <= trough_d;
         ERR    <= err_d;
         if (IN_VALID) p <= IN;
         if (err_d) begin
            ERR_CNT   <= sat_inc(ERR_CNT);
            peak_seen <= 1'b0;
         end
         // First peak after lock only arms the measurement.
         if (IN_VALID && locked_cur) begin
            if (peak_d) begin
               if (peak_seen) PERIOD <= sat_inc(cnt);
               cnt       <= '0;
               peak_seen <= 1'b1;
            end else begin
               cnt <= sat_inc(cnt);
            end
         end
      end
   end

endmodule

// File: tb/tb_triangle_monitor.sv
// Bench for triangle_monitor: directed vector table plus streams checked
// against a model that tracks the position within the ideal waveform.
module tb_triangle_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       locked, dir, peak, trough, err;
   logic [7:0] err_cnt, period;

   triangle_monitor #(.W(4), .CW(8)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN(in_data),
      .LOCKED(locked), .DIR(dir), .PEAK(peak), .TROUGH(trough), .ERR(err),
      .ERR_CNT(err_cnt), .PERIOD(period)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Ideal waveform: one 32-sample period starting at the double zero.
   int seq[32];

   // Model: 0 = waiting first sample, 1 = acquiring, 2 = locked at index m_pos.
   int m_stage, m_pos, m_p, m_ec, m_per, m_idx, m_last_peak;
   logic m_pk, m_tr, m_er;

   task automatic model_reset();
      m_stage = 0; m_pos = 0; m_p = 0; m_ec = 0; m_per = 0;
      m_idx = 0; m_last_peak = -1; m_pk = 0; m_tr = 0; m_er = 0;
   endtask

   task automatic model_step(input int s);
      m_pk = 0; m_tr = 0; m_er = 0;
      m_idx++;
      if (m_stage == 0) begin
         m_stage = 1;
      end else if (m_stage == 1) begin
         for (int k = 0; k < 32; k++)
            if (seq[(k + 31) % 32] == m_p && seq[k] == s) begin
               m_stage = 2;
               m_pos   = k;
            end
      end else if (s == seq[(m_pos + 1) % 32]) begin
         m_pos = (m_pos + 1) % 32;
         if (m_pos == 17) begin
            m_pk = 1;
            if (m_last_peak >= 0)
               m_per = (m_idx - m_last_peak > 255) ? 255 : m_idx - m_last_peak;
            m_last_peak = m_idx;
         end
         if (m_pos == 1) m_tr = 1;
      end else begin
         m_er = 1;
         if (m_ec < 255) m_ec++;
         m_stage     = 1;
         m_last_peak = -1;
      end
      m_p = s;
   endtask

   task automatic drive(input logic v, input logic [3:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
      if (v) model_step(int'(d));
      else begin
         m_pk = 0; m_tr = 0; m_er = 0;
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [20:0] act, exp;
      logic m_lk, m_dr;
      m_lk = (m_stage == 2);
      m_dr = m_lk && (m_pos >= 17 || m_pos == 0);
      act = {locked, dir, peak, trough, err, err_cnt, period};
      exp = {m_lk, m_dr, m_pk, m_tr, m_er, 8'(m_ec), 8'(m_per)};
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (lk,dir,pk,tr,err,ecnt,per)", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct packed {
      logic       v;
      logic [3:0] d;
      logic       lk, dr, pk, tr, er;
      logic [7:0] ec;
   } vec_t;

   vec_t tbl[21];

   initial begin
      int k, peaks;
      logic v;
      logic [3:0] d;

      for (int i = 0; i < 32; i++)
         seq[i] = (i == 0) ? 0 : (i <= 16) ? i - 1 : 32 - i;

      //             v     d     lk    dr    pk    tr    er    ec
      tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[3]  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[6]  = '{1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[7]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[8]  = '{1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[9]  = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[10] = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[11] = '{1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[12] = '{1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[13] = '{1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[14] = '{1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[15] = '{1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[16] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[17] = '{1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
      tbl[18] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
      tbl[19] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
      tbl[20] = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};

      // Reset state and directed error/no-wrap vectors
      do_reset();
      check_model("reset_state");
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].v, tbl[i].d);
         n_chk++;
         if ({locked, dir, peak, trough, err, err_cnt} !==
             {tbl[i].lk, tbl[i].dr, tbl[i].pk, tbl[i].tr, tbl[i].er, tbl[i].ec}) begin
            n_fail++;
            $display("FAIL table[%0d]: got lk%b dir%b pk%b tr%b err%b ec%0d want lk%b dir%b pk%b tr%b err%b ec%0d",
                     i, locked, dir, peak, trough, err, err_cnt,
                     tbl[i].lk, tbl[i].dr, tbl[i].pk, tbl[i].tr, tbl[i].er, tbl[i].ec);
         end
      end
      check_val("table_period", int'(period), 0);

      // Clean continuous stream
      do_reset();
      peaks = 0;
      for (k = 0; k < 128; k++) begin
         drive(1'b1, 4'(seq[k % 32]));
         check_model("clean_stream");
         if (peak) peaks++;
      end
      check_val("clean_peaks", peaks, 4);
      check_val("clean_period", int'(period), 32);
      check_val("clean_errcnt", int'(err_cnt), 0);

      // Same stream with random gaps in IN_VALID
      do_reset();
      k = 0;
      for (int c = 0; c < 400; c++) begin
         v = ($urandom_range(0, 9) < 7);
         d = v ? 4'(seq[k % 32]) : 4'($urandom_range(0, 15));
         if (v) k++;
         drive(v, d);
         check_model("gapped_stream");
      end
      check_val("gapped_period", int'(period), 32);
      check_val("gapped_errcnt", int'(err_cnt), 0);

      // Stream with occasional random corruption and gaps
      do_reset();
      k = 0;
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(0, 9) < 8);
         d = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'(seq[k % 32]);
         if (v) k++;
         drive(v, d);
         check_model("corrupt_stream");
      end

      // Asynchronous reset between clock edges, then relock from scratch
      do_reset();
      for (k = 0; k < 60; k++) drive(1'b1, 4'(seq[k % 32]));
      check_model("pre_async_rst");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_val("async_rst_outputs",
                int'({locked, dir, peak, trough, err, err_cnt, period}), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (k = 0; k < 81; k++) begin
         drive(1'b1, 4'(seq[k % 32]));
         check_model("relock_stream");
      end
      check_val("relock_period", int'(period), 32);

      // Error counter saturation; PERIOD must survive the errors
      for (int i = 0; i < 301; i++) begin
         drive(1'b1, 4'd5);
         check_model("sat_err");
         drive(1'b1, 4'd0);
         drive(1'b1, 4'd0);
         check_model("sat_relock");
      end
      check_val("errcnt_saturated", int'(err_cnt), 255);
      check_val("period_after_errors", int'(period), 32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
